// File: rtl/press_pkg.sv
// Shared types and constants for the press-duration arbiter.
package press_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_CDOWN    = 2'd3
  } press_state_t;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam int TIME_W_DEFAULT = 4;

endpackage

// File: rtl/press_arbiter_if.sv
// Button/event handshake bundle between the button front end, the arbiter and the game logic.
interface press_arbiter_if #(
  parameter int N_BTN  = 4,
  parameter int TIME_W = press_pkg::TIME_W_DEFAULT
);
  import press_pkg::*;

  logic [N_BTN-1:0]  btn;
  logic              ack;
  logic              busy;
  dir_t              owner;
  logic [TIME_W-1:0] press_time;
  logic              evt_valid;
  dir_t              evt_dir;
  logic [TIME_W-1:0] evt_time;

  modport master (
    output btn, ack,
    input  busy, owner, press_time, evt_valid, evt_dir, evt_time
  );

  modport slave (
    input  btn, ack,
    output busy, owner, press_time, evt_valid, evt_dir, evt_time
  );

endinterface

// File: rtl/press_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles, shared by hold timing and cooldown.
module press_tick_gen
  import press_pkg::*;
#(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;

  assign tick = enable && (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (clear) begin
      div <= '0;
    end else if (enable) begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/press_arbiter.sv
// Grants the shared press timer to one button, times the hold, and emits a direction+duration event.
//  state    | meaning
//  IDLE     | no button owns the timer; waiting for any press
//  HOLD     | owner button held; press_time counts prescaled ticks
//  WAIT_ACK | event pending on evt_*; waiting for ack
//  CDOWN    | lockout of COOLDOWN ticks, then wait for all buttons released
module press_arbiter
  import press_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int TIME_W    = TIME_W_DEFAULT,
  parameter int TICK_DIV  = 2500000,
  parameter int MIN_PRESS = 1,
  parameter int COOLDOWN  = 2
) (
  input  logic           clk,
  input  logic           rst,
  press_arbiter_if.slave bus
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0]   CD_MAX   = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0]   CD_LAST  = CD_W'(COOLDOWN - 1);
  localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0] MIN_T    = TIME_W'(MIN_PRESS);

  press_state_t    state;
  logic [CD_W-1:0] cd_cnt;
  logic            tick;
  logic            div_en;
  logic            div_clr;
  logic            cd_done;
  logic            any_btn;
  logic            own_btn;
  dir_t            grant_idx;

  // Lowest index wins on simultaneous presses.
  always_comb begin
    grant_idx = DIR_UP;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (bus.btn[i]) grant_idx = dir_t'(i);
    end
  end

  assign any_btn = |bus.btn;
  assign own_btn = bus.btn[bus.owner];

  // Divider restarts on every entry to HOLD or CDOWN; the release cycle never counts.
  assign div_en  = ((state == ST_HOLD) && own_btn) ||
                   ((state == ST_CDOWN) && (cd_cnt != CD_MAX));
  assign div_clr = (state == ST_IDLE) || (state == ST_WAIT_ACK) ||
                   ((state == ST_HOLD) && !own_btn);
  assign cd_done = (cd_cnt == CD_MAX) || ((cd_cnt == CD_LAST) && tick);

  press_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (div_en),
    .clear  (div_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cd_cnt         <= '0;
      bus.busy       <= 1'b0;
      bus.owner      <= DIR_UP;
      bus.press_time <= '0;
      bus.evt_valid  <= 1'b0;
      bus.evt_dir    <= DIR_UP;
      bus.evt_time   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_btn) begin
            state          <= ST_HOLD;
            bus.busy       <= 1'b1;
            bus.owner      <= grant_idx;
            bus.press_time <= '0;
          end
        end
        ST_HOLD: begin
          if (own_btn) begin
            if (tick && (bus.press_time != TIME_MAX))
              bus.press_time <= bus.press_time + 1'b1;
          end else begin
            bus.owner      <= DIR_UP;
            bus.press_time <= '0;
            cd_cnt         <= '0;
            if (bus.press_time >= MIN_T) begin
              state         <= ST_WAIT_ACK;
              bus.evt_valid <= 1'b1;
              bus.evt_dir   <= bus.owner;
              bus.evt_time  <= bus.press_time;
            end else begin
              state <= ST_CDOWN;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (bus.ack) begin
            state         <= ST_CDOWN;
            bus.evt_valid <= 1'b0;
            cd_cnt        <= '0;
          end
        end
        ST_CDOWN: begin
          if (tick) cd_cnt <= cd_cnt + 1'b1;
          if (cd_done && !any_btn) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_press_arbiter.sv
// Randomized scoreboard bench for press_arbiter with a press-level reference model.
module tb_press_arbiter;

  localparam int TICK_DIV  = 4;
  localparam int COOLDOWN  = 2;
  localparam int MIN_PRESS = 1;
  localparam int TMAX      = 15;

  typedef struct {
    int dir;
    int t;
  } ev_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  ev_t  exp_q[$];

  press_arbiter_if #(.N_BTN(4), .TIME_W(4)) bus ();

  press_arbiter #(
    .N_BTN     (4),
    .TIME_W    (4),
    .TICK_DIV  (TICK_DIV),
    .MIN_PRESS (MIN_PRESS),
    .COOLDOWN  (COOLDOWN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [3:0] pat);
    for (int i = 0; i < 4; i++) if (pat[i]) return i;
    return 0;
  endfunction

  function automatic int model_time(input int k);
    int t;
    t = k / TICK_DIV;
    return (t > TMAX) ? TMAX : t;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_owner"}, int'(bus.owner), 0);
    chk({tag, "_press_time"}, int'(bus.press_time), 0);
    chk({tag, "_evt_valid"}, int'(bus.evt_valid), 0);
    chk({tag, "_evt_dir"}, int'(bus.evt_dir), 0);
    chk({tag, "_evt_time"}, int'(bus.evt_time), 0);
  endtask

  // Count cycles the block stays busy, starting at the negedge after the edge that entered cooldown.
  task automatic measure_cooldown();
    int cyc;
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("cooldown_cycles", cyc, COOLDOWN * TICK_DIV);
  endtask

  // One complete press: grant, hold k cycles, release, optional ack, cooldown. Starts/ends at a negedge.
  task automatic do_press(input logic [3:0] pat, input int k, input int ack_dly, input bit noisy);
    int  exp_dir;
    int  exp_t;
    bit  exp_evt;
    ev_t e;
    exp_dir = lowest_set(pat);
    exp_t   = model_time(k);
    exp_evt = (exp_t >= MIN_PRESS);
    chk("idle_before_press", int'(bus.busy), 0);
    bus.btn = pat;
    @(posedge clk);
    @(negedge clk);
    chk("grant_busy", int'(bus.busy), 1);
    chk("grant_owner", int'(bus.owner), exp_dir);
    for (int j = 1; j <= k; j++) begin
      if (noisy) begin
        bus.btn = 4'($urandom_range(0, 15)) | 4'(1 << exp_dir);
        bus.ack = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);
      chk("hold_press_time", int'(bus.press_time), model_time(j));
      chk("hold_owner", int'(bus.owner), exp_dir);
    end
    bus.btn = 4'b0000;
    bus.ack = 1'b0;
    if (exp_evt) begin
      e.dir = exp_dir;
      e.t   = exp_t;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk("release_evt_valid", int'(bus.evt_valid), int'(exp_evt));
    chk("release_owner", int'(bus.owner), 0);
    chk("release_press_time", int'(bus.press_time), 0);
    chk("release_busy", int'(bus.busy), 1);
    if (exp_evt) begin
      for (int j = 0; j < ack_dly; j++) begin
        @(posedge clk);
        @(negedge clk);
        chk("wait_evt_valid", int'(bus.evt_valid), 1);
        chk("wait_evt_dir", int'(bus.evt_dir), exp_dir);
        chk("wait_evt_time", int'(bus.evt_time), exp_t);
      end
      bus.ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ack = 1'b0;
      chk("ack_evt_valid", int'(bus.evt_valid), 0);
    end
    measure_cooldown();
  endtask

  // Scoreboard monitor: compare each newly presented event against the queue head.
  initial begin
    bit  prev;
    ev_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (bus.evt_valid && !prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_evt: got dir=%0d time=%0d, expected no event", bus.evt_dir, bus.evt_time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_evt_dir", int'(bus.evt_dir), e.dir);
            chk("sb_evt_time", int'(bus.evt_time), e.t);
          end
        end
        prev = bus.evt_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ev_t e;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    bus.btn = 4'b0000;
    bus.ack = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("after_reset_busy", int'(bus.busy), 0);

    // Basic: left held for 12 cycles, ack after 5.
    do_press(4'b0100, 12, 5, 1'b0);
    // Priority: down beats right; non-owners toggle freely during hold.
    do_press(4'b1010, 8, 0, 1'b1);
    // Saturation.
    do_press(4'b0001, 100, 2, 1'b0);
    // Glitch: too short for an event.
    do_press(4'b1000, 3, 0, 1'b0);

    // Reset mid-HOLD clears everything at once.
    bus.btn = 4'b0001;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_press_time", int'(bus.press_time), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_reset_hold");
    bus.btn = 4'b0000;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", int'(bus.busy), 0);
    do_press(4'b0010, 5, 1, 1'b0);

    // Reset with an event pending discards it.
    bus.btn = 4'b1000;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.btn = 4'b0000;
    e.dir = 3;
    e.t   = 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("pending_evt_valid", int'(bus.evt_valid), 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset_pending");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Re-arm: a button held through ack and cooldown never re-grants.
    bus.btn = 4'b0010;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.btn = 4'b0100;
    e.dir = 1;
    e.t   = 2;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("rearm_evt_valid", int'(bus.evt_valid), 1);
    bus.ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ack = 1'b0;
    chk("rearm_ack_evt_valid", int'(bus.evt_valid), 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rearm_busy_held", int'(bus.busy), 1);
    chk("rearm_owner", int'(bus.owner), 0);
    chk("rearm_no_event", int'(bus.evt_valid), 0);
    bus.btn = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk("rearm_release_idle", int'(bus.busy), 0);
    do_press(4'b0100, 6, 0, 1'b0);

    // Randomized presses.
    for (int n = 0; n < 25; n++) begin
      do_press(4'($urandom_range(1, 15)), $urandom_range(0, 80), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/press_arbiter.md
# press_arbiter

Shares one press-duration timer among the four direction buttons of the game controller. It grants the timer to one button at a time and measures that button's hold time in prescaled ticks, with 4-bit saturation. On release it issues a single direction-plus-duration event to the game logic through a valid/ack handshake. It sits between the synchronized button inputs and the game-state/display logic.

## Interface
- N_BTN, 4, number of requesting buttons; index encodes direction: 0 up, 1 down, 2 left, 3 right
- TIME_W, 4, width of the press-time count
- TICK_DIV, 2500000, clk cycles per press-time unit (100 ms at 25 MHz); must be ≥2
- MIN_PRESS, 1, minimum press_time for an event; shorter presses are discarded
- COOLDOWN, 2, ticks of lockout after each press

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- btn  in  N_BTN  button levels, already synchronized/debounced upstream; 1 = pressed
- ack  in  1  event consumed; sampled only while evt_valid=1
- busy  out  1  high in every state except IDLE
- owner  out  2  index of granted button; 0 outside HOLD
- press_time  out  TIME_W  live count in HOLD; 0 otherwise
- evt_valid  out  1  event pending
- evt_dir  out  2  direction of pending event
- evt_time  out  TIME_W  duration of pending event

## Operation
- States: IDLE, HOLD, WAIT_ACK, CDOWN. All outputs and internal counters reset to 0, and the state resets to IDLE.
- IDLE: when btn≠0, grant the lowest set index, clear press_time and the divider, and go to HOLD.
- HOLD: the timer is owned by btn[owner]; all other buttons are ignored.
  - Each cycle with btn[owner]=1: if div==TICK_DIV-1, set div←0 and press_time←press_time+1, saturating at 2^TIME_W−1; otherwise div←div+1.
  - After k HOLD cycles, press_time = min(floor(k/TICK_DIV), 15).
- Release while in HOLD (btn[owner]=0):
  - press_time≥MIN_PRESS: latch evt_dir←owner and evt_time←press_time, set evt_valid←1, go to WAIT_ACK.
  - Otherwise: go to CDOWN with no event.
  - On the release cycle there is no increment, even if the divider would wrap.
- WAIT_ACK: evt_valid, evt_dir and evt_time are held stable. ack=1 clears evt_valid and goes to CDOWN. ack while evt_valid=0 is ignored.
- CDOWN: counts COOLDOWN×TICK_DIV cycles. Once the count expires, the block returns to IDLE only when btn==0. A button held continuously therefore never re-grants.
- Asynchronous reset in any state, including with an event pending, discards the event immediately.

## Timing
- Grant latency: btn sampled at edge n; busy, owner and state=HOLD are valid after edge n.
- Event latency: release sampled at edge n; evt_valid=1 after edge n.
- Earliest ack: the cycle after evt_valid rises. evt_valid falls at the edge that samples ack=1.
- Simultaneous presses: the lowest index wins.
- Press of a non-owner during HOLD: no effect, and it is not queued.
- Minimum spacing between events: release → ack → COOLDOWN×TICK_DIV cycles → all buttons released → next grant.

## Structure
- Package press_pkg holds:
  - the state enum
  - direction constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3
  - the TIME_W default
- Sub-module press_tick_gen is the prescaler: inputs enable and clear; output a one-cycle tick when the count reaches TICK_DIV-1. It is shared by the HOLD and CDOWN counting.
- The remaining logic (priority encoder, FSM, event registers) stays in press_arbiter.

## Test plan
All scenarios use TICK_DIV=4, COOLDOWN=2, MIN_PRESS=1.
- Reset: assert rst mid-HOLD → busy, owner, press_time, evt_valid, evt_dir, evt_time all 0 immediately; state is IDLE after deassertion.
- Basic: btn=0100 for 12 HOLD cycles, then 0 → evt_valid=1, evt_dir=2, evt_time=3. Hold ack=0 for 5 cycles → evt_* unchanged. Pulse ack → evt_valid=0; busy stays 1 for 8 cycles, then drops.
- Priority: btn=1010 → owner=1. Toggle btn[3] during HOLD → no effect. Release btn[1] after 8 cycles → evt_dir=1, evt_time=2.
- Saturation: hold btn[0] for 100 HOLD cycles → press_time stops at 15; event evt_time=15.
- Glitch: btn[3] for 3 HOLD cycles → no evt_valid; busy=1 through cooldown.
- Re-arm: keep btn[2] high through ack and cooldown → stays in CDOWN, no new grant. Release, then press again → new grant with owner=2.
